// File: rtl/altro_readout_tx.sv
// ALTRO-bus readout transmitter: fetches NSAMP 10-bit samples of one channel,
// strobes them out packed four per 40-bit word, then sends the trailer word.
module altro_readout_tx #(
  parameter int NSAMP = 128,
  parameter int IDX_W = 7
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             data_out_sign,
  input  logic [6:0]       point_address,
  input  logic [39:0]      last_40bit,
  output logic             rd_en,
  output logic [6:0]       rd_chan,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [9:0]       rd_data,
  output logic [39:0]      bd_out,
  output logic             dstb,
  output logic             trsf,
  output logic             busy
);
  localparam int WORD_W = IDX_W - 2;
  localparam logic [WORD_W-1:0] LAST_W = WORD_W'(NSAMP/4 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FETCH, S_CAP, S_STROBE, S_TRAILER, S_DONE
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_word;
  logic [1:0]        r_k;
  logic              r_rd_en, r_rd_en_q, r_dstb, r_trsf, r_busy;
  logic [6:0]        r_rd_chan;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [39:0]       r_bd;
  logic [29:0]       r_sh;   // samples j=0..2 of the current word, j=0 lowest

  assign rd_en   = r_rd_en;
  assign rd_chan = r_rd_chan;
  assign rd_idx  = r_rd_idx;
  assign bd_out  = r_bd;
  assign dstb    = r_dstb;
  assign trsf    = r_trsf;
  assign busy    = r_busy;

  always_ff @(posedge rclk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_word    <= '0;
      r_k       <= '0;
      r_rd_en   <= 1'b0;
      r_rd_en_q <= 1'b0;
      r_dstb    <= 1'b1;
      r_trsf    <= 1'b1;
      r_busy    <= 1'b0;
      r_rd_chan <= '0;
      r_rd_idx  <= '0;
      r_bd      <= '0;
      r_sh      <= '0;
    end else begin
      r_dstb    <= 1'b1;
      r_rd_en_q <= r_rd_en;
      // Buffer data lands one cycle after rd_en; shift it in as it arrives.
      if (r_rd_en_q) r_sh <= {rd_data, r_sh[29:10]};

      if (r_state != S_IDLE && r_state != S_DONE && !data_out_sign) begin
        r_state <= S_IDLE;
        r_trsf  <= 1'b1;
        r_rd_en <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (data_out_sign) begin
            r_state   <= S_ARM;
            r_rd_chan <= point_address;
            r_word    <= '0;
            r_k       <= '0;
            r_busy    <= 1'b1;
          end
          S_ARM: begin
            r_trsf  <= 1'b0;
            r_state <= S_FETCH;
          end
          S_FETCH: begin
            r_rd_en  <= 1'b1;
            r_rd_idx <= {r_word, r_k};
            r_k      <= r_k + 2'd1;
            if (r_k == 2'd3) r_state <= S_CAP;
          end
          S_CAP: begin
            r_rd_en <= 1'b0;
            r_state <= S_STROBE;
          end
          S_STROBE: begin
            // Fourth sample is on rd_data right now, the other three in r_sh.
            r_dstb <= 1'b0;
            r_bd   <= {rd_data, r_sh};
            if (r_word == LAST_W) begin
              r_state <= S_TRAILER;
            end else begin
              r_word  <= r_word + WORD_W'(1);
              r_state <= S_FETCH;
            end
          end
          S_TRAILER: begin
            r_dstb  <= 1'b0;
            r_bd    <= last_40bit;
            r_state <= S_DONE;
          end
          S_DONE: begin
            r_trsf <= 1'b1;
            if (!data_out_sign) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_altro_readout_tx.sv
// Scoreboard bench: stimulus pushes expected bus words, negedge monitors pop
// and compare on every dstb pulse. Two instances cover NSAMP=8 and NSAMP=128.
module tb_altro_readout_tx;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic s8 = 1'b0, s128 = 1'b0;
  logic [6:0] pa8 = '0, pa128 = '0;
  logic [39:0] last8 = '0, last128 = '0;
  logic rd_en8, rd_en128, dstb8, dstb128, trsf8, trsf128, busy8, busy128;
  logic [6:0] rd_chan8, rd_chan128;
  logic [2:0] rd_idx8;
  logic [6:0] rd_idx128;
  logic [9:0] rdat8 = '0, rdat128 = '0;
  logic [39:0] bd8, bd128;

  altro_readout_tx #(.NSAMP(8), .IDX_W(3)) u8 (
    .rclk(clk), .reset(rst_n), .data_out_sign(s8), .point_address(pa8),
    .last_40bit(last8), .rd_en(rd_en8), .rd_chan(rd_chan8), .rd_idx(rd_idx8),
    .rd_data(rdat8), .bd_out(bd8), .dstb(dstb8), .trsf(trsf8), .busy(busy8));

  altro_readout_tx #(.NSAMP(128), .IDX_W(7)) u128 (
    .rclk(clk), .reset(rst_n), .data_out_sign(s128), .point_address(pa128),
    .last_40bit(last128), .rd_en(rd_en128), .rd_chan(rd_chan128), .rd_idx(rd_idx128),
    .rd_data(rdat128), .bd_out(bd128), .dstb(dstb128), .trsf(trsf128), .busy(busy128));

  int checks = 0, failures = 0;
  logic [39:0] q8[$], q128[$];
  int eidx8 = 0, eidx128 = 0, nstb8 = 0, nstb128 = 0;
  int lo8 = 0, lo128 = 0, len8 = 0, len128 = 0;
  logic [6:0] echan8 = '0, echan128 = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] fdat(logic [6:0] c, int i);
    return {c, 3'b000} + 10'(i);
  endfunction

  function automatic logic [39:0] pack(logic [6:0] c, int w);
    logic [39:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[10*j +: 10] = fdat(c, 4*w + j);
    return r;
  endfunction

  // Sample buffer models: registered read, data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en8)   rdat8   <= fdat(rd_chan8, int'(rd_idx8));
    if (rd_en128) rdat128 <= fdat(rd_chan128, int'(rd_idx128));
  end

  always @(negedge clk) if (rst_n) begin
    if (!dstb8) begin
      nstb8++;
      if (q8.size() == 0) chk("d8 unexpected strobe", {24'd0, bd8}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("d8 word", {24'd0, bd8}, {24'd0, q8.pop_front()});
    end
    if (rd_en8) begin
      chk("d8 rd_idx", 64'(rd_idx8), 64'(eidx8 % 8));
      chk("d8 rd_chan", 64'(rd_chan8), 64'(echan8));
      eidx8++;
    end
    if (!trsf8) lo8++;
    else if (lo8 != 0) begin len8 = lo8; lo8 = 0; end
  end

  always @(negedge clk) if (rst_n) begin
    if (!dstb128) begin
      nstb128++;
      if (q128.size() == 0) chk("d128 unexpected strobe", {24'd0, bd128}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("d128 word", {24'd0, bd128}, {24'd0, q128.pop_front()});
    end
    if (rd_en128) begin
      chk("d128 rd_idx", 64'(rd_idx128), 64'(eidx128));
      chk("d128 rd_chan", 64'(rd_chan128), 64'(echan128));
      eidx128++;
    end
    if (!trsf128) lo128++;
    else if (lo128 != 0) begin len128 = lo128; lo128 = 0; end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push8(logic [6:0] c);
    for (int w = 0; w < 2; w++) q8.push_back(pack(c, w));
    q8.push_back(last8);
  endtask

  task automatic wait_done8(int exp_len);
    int n;
    n = 0;
    len8 = 0;
    while (len8 == 0 && n < 100) begin tick(); n++; end
    chk("d8 trsf low length", 64'(len8), 64'(exp_len));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    last8 = 40'hA5_5A5A_0101;
    last128 = 40'h3C_C3C3_7E7E;
    tick(); tick();
    chk("reset trsf", 64'(trsf8), 64'd1);
    chk("reset dstb", 64'(dstb8), 64'd1);
    chk("reset rd_en", 64'(rd_en8), 64'd0);
    chk("reset busy", 64'(busy8), 64'd0);
    chk("reset bd_out", {24'd0, bd8}, 64'd0);
    chk("reset rd_idx/chan", {rd_idx8, rd_chan8}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: NSAMP=8, rd_data=idx, sign held high for 20 cycles
    pa8 = 7'h00; echan8 = 7'h00; eidx8 = 0;
    q8.push_back(40'h00C0200400);
    q8.push_back(40'h01C0601404);
    q8.push_back(last8);
    s8 = 1'b1;
    tick();                                   // edge N
    chk("t1 busy after trigger", 64'(busy8), 64'd1);
    chk("t1 trsf at N", 64'(trsf8), 64'd1);
    tick();                                   // N+1
    chk("t1 trsf low at N+1", 64'(trsf8), 64'd0);
    for (int i = 0; i < 5; i++) tick();       // N+6
    chk("t1 dstb high at N+6", 64'(dstb8), 64'd1);
    tick();                                   // N+7
    chk("t1 dstb low at N+7", 64'(dstb8), 64'd0);
    for (int i = 8; i < 20; i++) tick();
    chk("t1 trsf low length", 64'(len8), 64'd14);
    chk("t1 trsf released", 64'(trsf8), 64'd1);
    chk("t1 busy in DONE", 64'(busy8), 64'd1);
    chk("t1 all words seen", 64'(q8.size()), 64'd0);
    s8 = 1'b0;
    tick();
    chk("t1 busy after drop", 64'(busy8), 64'd0);

    // 2: NSAMP=128, channel 7F
    pa128 = 7'h7F; echan128 = 7'h7F; eidx128 = 0; nstb128 = 0;
    for (int w = 0; w < 32; w++) q128.push_back(pack(7'h7F, w));
    q128.push_back(last128);
    s128 = 1'b1;
    begin
      int n;
      n = 0;
      len128 = 0;
      while (len128 == 0 && n < 400) begin tick(); n++; end
    end
    chk("t2 trsf low length", 64'(len128), 64'd194);
    chk("t2 strobe count", 64'(nstb128), 64'd33);
    chk("t2 rd_chan", 64'(rd_chan128), 64'h7F);
    chk("t2 busy in DONE", 64'(busy128), 64'd1);
    chk("t2 all words seen", 64'(q128.size()), 64'd0);
    s128 = 1'b0;
    tick();
    chk("t2 busy after drop", 64'(busy128), 64'd0);

    // 3: abort during the 2nd FETCH
    pa8 = 7'h02; echan8 = 7'h02; eidx8 = 0;
    nstb8 = 0;
    q8.push_back(pack(7'h02, 0));
    s8 = 1'b1;
    tick();                                   // N
    for (int i = 0; i < 8; i++) tick();       // N+8, FETCH k=1 of word 1
    s8 = 1'b0;
    tick();
    chk("t3 trsf after abort", 64'(trsf8), 64'd1);
    chk("t3 dstb after abort", 64'(dstb8), 64'd1);
    chk("t3 rd_en after abort", 64'(rd_en8), 64'd0);
    chk("t3 busy after abort", 64'(busy8), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("t3 strobe count", 64'(nstb8), 64'd1);
    chk("t3 no trailer", 64'(q8.size()), 64'd0);

    // 4: level held after DONE must not re-trigger
    pa8 = 7'h03; echan8 = 7'h03; eidx8 = 0;
    push8(7'h03);
    s8 = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i >= 20) chk("t4 trsf stays high", 64'(trsf8), 64'd1);
    end
    chk("t4 first transfer len", 64'(len8), 64'd14);
    chk("t4 first transfer words", 64'(q8.size()), 64'd0);
    s8 = 1'b0;
    tick();
    eidx8 = 0;
    push8(7'h03);
    s8 = 1'b1;
    wait_done8(14);
    chk("t4 retrigger words", 64'(q8.size()), 64'd0);
    s8 = 1'b0;
    tick();

    // 6: point_address change in the 3rd cycle is ignored
    pa8 = 7'h05; echan8 = 7'h05; eidx8 = 0;
    push8(7'h05);
    s8 = 1'b1;
    tick(); tick(); tick();
    pa8 = 7'h12;
    wait_done8(14);
    chk("t6 rd_chan frozen", 64'(rd_chan8), 64'h05);
    chk("t6 words", 64'(q8.size()), 64'd0);
    s8 = 1'b0;
    tick();

    // 5: async reset mid-STROBE
    pa8 = 7'h05; echan8 = 7'h05; eidx8 = 0;
    s8 = 1'b1;
    tick();                                   // N
    for (int i = 0; i < 6; i++) tick();       // N+6, state STROBE
    rst_n = 1'b0;
    #1;
    chk("t5 async trsf", 64'(trsf8), 64'd1);
    chk("t5 async dstb", 64'(dstb8), 64'd1);
    chk("t5 async rd_en", 64'(rd_en8), 64'd0);
    chk("t5 async busy", 64'(busy8), 64'd0);
    chk("t5 async bd_out", {24'd0, bd8}, 64'd0);
    chk("t5 async rd_idx/chan", {rd_idx8, rd_chan8}, 64'd0);
    s8 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t5 idle trsf", 64'(trsf8), 64'd1);
    chk("t5 idle busy", 64'(busy8), 64'd0);
    pa8 = 7'h01; echan8 = 7'h01; eidx8 = 0;
    push8(7'h01);
    s8 = 1'b1;
    wait_done8(14);
    chk("t5 recovery words", 64'(q8.size()), 64'd0);
    s8 = 1'b0;
    tick(); tick();

    chk("end q8 empty", 64'(q8.size()), 64'd0);
    chk("end q128 empty", 64'(q128.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
